// File: rtl/nand_tester.sv
// Stimulus/response tester for a 2-input combinational gate: walks all four
// input vectors, samples the gate output after a settle time, and reports mismatches.

module nand_tester #(
   parameter int unsigned SETTLE = 2,
   parameter logic [3:0]  EXPECT = 4'b0111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dut_x,
   output logic       dut_a,
   output logic       dut_b,
   output logic [1:0] vec_idx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_mask
);

   localparam int unsigned CNT_W    = 8;
   localparam int unsigned VEC_W    = 2;
   localparam int unsigned NUM_VEC  = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [VEC_W-1:0]    vec_q;
   logic [NUM_VEC-1:0]  err_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;

   logic                mismatch_c;
   logic [NUM_VEC-1:0]  err_d;

   // Compare the gate output against the expected truth-table entry
   always_comb begin
      mismatch_c     = (dut_x != EXPECT[vec_q]);
      err_d          = err_q;
      err_d[vec_q]   = mismatch_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         vec_q   <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q <= ST_SETTLE;
                  cnt_q   <= '0;
                  vec_q   <= '0;
                  err_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end
            end

            ST_SETTLE: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q <= ST_SAMPLE;
               end
            end

            ST_SAMPLE: begin
               err_q <= err_d;
               if (vec_q != VEC_LAST) begin
                  vec_q   <= vec_q + VEC_W'(1);
                  cnt_q   <= '0;
                  state_q <= ST_SETTLE;
               end else begin
                  // Final verdict includes this cycle's compare
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == '0);
                  state_q <= ST_DONE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign dut_a    = vec_q[1];
   assign dut_b    = vec_q[0];
   assign vec_idx  = vec_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_mask = err_q;

endmodule

// File: doc/nand_tester.md
# nand_tester

Self-checking stimulus/response driver for a 2-input combinational gate such as the lab NAND gate. On `start` it drives all four input vectors onto the gate under test and waits a programmable settle time for each. It then samples the gate output and compares it against an expected truth table. It sits beside the gate on the board/bench, driving the gate's `a`/`b` inputs and reading its `x` output, and reports per-vector mismatches plus an overall pass flag.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range 1..255.
- `EXPECT`, default 4'b0111: expected truth table; bit index = {a,b}, bit value = expected x (NAND).
- `clk` in, 1: single clock, all state on rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: request a test run; sampled on rising edge.
- `dut_x` in, 1: output of gate under test.
- `dut_a` out, 1: drives gate input a (registered).
- `dut_b` out, 1: drives gate input b (registered).
- `vec_idx` out, 2: index {a,b} of vector currently applied.
- `busy` out, 1: high while a run is in progress.
- `done` out, 1: level, high from run completion until next accepted start.
- `pass` out, 1: valid when done; 1 iff err_mask == 0.
- `err_mask` out, 4: bit i set iff vector i mismatched.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE. Reset state is IDLE.
- IDLE/DONE + start=1 → SETTLE. At that edge: vec_idx<=0, {dut_a,dut_b}<=2'b00, cnt<=0, err_mask<=0, busy<=1, done<=0, pass<=0.
- SETTLE: cnt increments each cycle. When cnt == SETTLE-1 → SAMPLE.
- SAMPLE, one cycle: err_mask[vec_idx] <= (dut_x != EXPECT[vec_idx]).
  - If vec_idx != 3: vec_idx+1, {dut_a,dut_b} <= new vec_idx, cnt<=0 → SETTLE.
  - If vec_idx == 3 → DONE: busy<=0, done<=1, pass <= (final err_mask == 0), including this cycle's compare result.
- {dut_a,dut_b} always equals vec_idx; the outputs hold their last value (2'b11) in DONE.
- start while busy is ignored; no queuing.
- start in DONE restarts a full run and clears done/pass/err_mask.
- dut_x is used directly, with no synchronizer. It is only sampled in SAMPLE, so transients during SETTLE are don't-care.
- cnt is 8 bits and never wraps, because SETTLE ≤ 255.

## Timing
- Reset values: dut_a=0, dut_b=0, vec_idx=0, busy=0, done=0, pass=0, err_mask=0. These apply immediately on rst_n low, independent of clk.
- Reset mid-run aborts the run; no partial result is retained. After reset release the block waits in IDLE for start.
- Let t0 be the edge that accepts start. Vector k is applied from edge t0+k·(SETTLE+1) and sampled at edge t0+k·(SETTLE+1)+SETTLE+1.
- done, pass and final err_mask all become visible together after edge t0+4·(SETTLE+1), e.g. 12 cycles for SETTLE=2.
- busy is high for exactly 4·(SETTLE+1) cycles.
- err_mask bits update incrementally, one per SAMPLE cycle. They are final only when done=1.
- Minimum restart: start held high in DONE is accepted on the first DONE-state edge.

## Test plan
- Ideal NAND attached, SETTLE=2, 1-cycle start pulse → busy high 12 cycles, dut_a/dut_b step 00,01,10,11, done=1, pass=1, err_mask=4'b0000.
- AND gate attached instead, default EXPECT → done after 12 cycles, pass=0, err_mask=4'b1111.
- dut_x stuck at 1, SETTLE=1 → done after 8 cycles, err_mask=4'b1000, pass=0.
- EXPECT=4'b1000 with AND attached, SETTLE=255 → done after 1024 cycles, pass=1.
- start pulsed again at cycle 5 of a run → ignored, completion still at cycle 12. Then start in DONE → done drops next cycle and a fresh 12-cycle run completes.
- rst_n asserted low mid-run, asynchronously between edges (e.g. during vector 2 SETTLE) → all outputs zero immediately. After release, block stays IDLE until start, then a normal run passes.
